bus_slave_mem: RTL and testbench
================================

Name: bus_slave_mem

Overview:
- Word-addressed memory responder on the CPU data bus; the target end of the initiator protocol (addr, as_, rw, wr_data, rd_data) driven by the MEM stage.
- Holds a 2^ADDR_W x 32 synchronous RAM array.
- Inserts a configurable number of wait states, then acknowledges each access with a one-cycle active-low rdy_ strobe.
- Sits behind the bus address decoder, which drives cs_.

Parameters:
ADDR_W, 10, word-index width; array depth = 2^ADDR_W words
WAIT_CYCLES, 1, wait states between request acceptance and acknowledge (0..15)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
cs_  input  1  chip select from bus decoder, active low
as_  input  1  address strobe from initiator, active low
rw  input  1  1 = read, 0 = write (READ/WRITE encodings)
addr  input  30  word address (byte address [31:2])
wr_data  input  32  write data
rd_data  output  32  read data; 0 except during a read acknowledge
rdy_  output  1  acknowledge strobe, active low, one cycle

Behaviour:
- Interface (already decided): one clock; reset is asynchronous and active-low. All outputs are registered.
- Reset (reset=0, any time): state=IDLE, rdy_=1, rd_data=0, wait counter=0, latched request cleared. Array contents are not reset. A request in flight is dropped; no write occurs.
- States: IDLE, WAIT, ACK.
- IDLE:
  - At a rising edge with cs_=0 and as_=0, latch addr, rw and wr_data.
  - Go to WAIT with cnt=WAIT_CYCLES-1 if WAIT_CYCLES>0; otherwise go directly to ACK.
- WAIT:
  - At each edge: if cs_=1 or as_=1, abort to IDLE (no write, no rdy_).
  - Else if cnt=0, go to ACK; else cnt=cnt-1.
- Entering ACK (same edge):
  - Read: rd_data <= mem[latched index].
  - Write: mem[latched index] <= latched wr_data.
  - rdy_ <= 0.
- ACK:
  - Lasts exactly one cycle, then unconditionally returns to IDLE.
  - At that edge: rdy_ <= 1, rd_data <= 0.
  - cs_/as_ are not sampled during ACK; back-to-back requests are separated by at least one IDLE cycle.
- Latency: request sampled at edge t0; rdy_ is low in the cycle following edge t0+WAIT_CYCLES (WAIT_CYCLES=0 gives rdy_ low the cycle right after t0).
- Index: the latched index is addr[ADDR_W-1:0].
- Out-of-range (addr[29:ADDR_W] != 0): still acknowledged after the normal latency. A read returns 0; a write is discarded.
- Initiator contract: hold cs_, as_, addr, rw and wr_data stable from request until the edge that ends the ACK cycle. Changes to addr/rw/wr_data after acceptance are ignored, because the latched values are used.
- rd_data=0 outside a read ACK so that slave outputs can be OR-combined on the bus.

Test Plan:
- Reset: drive reset=0 mid-WAIT of a write of 0xDEADBEEF to word 5, then release. Required: rdy_=1 and rd_data=0 immediately (asynchronous). A later read of word 5 does not return 0xDEADBEEF.
- WAIT_CYCLES=1, write then read: write 0x12345678 to addr 0x3, then read addr 0x3. Required: rdy_ low exactly 2 cycles after each request edge, for 1 cycle; read returns 0x12345678; rd_data=0 in every other cycle.
- WAIT_CYCLES=0, back-to-back writes: write 0xA5A5A5A5 to addr 0 and 0x5A5A5A5A to addr 0x3FF, holding as_ low continuously. Required: each acknowledged one cycle after its request edge, with one IDLE cycle between; readback returns both values. With ADDR_W=10, index 0x3FF (top word) is valid.
- Abort: assert a read request, deassert as_ during WAIT (WAIT_CYCLES=3). Required: no rdy_ pulse, state returns to IDLE, memory unchanged.
- Out-of-range: write 0xFFFFFFFF to addr 0x400 (ADDR_W=10), then read 0x400 and read 0x000. Required: both 0x400 accesses are acknowledged; the read of 0x400 returns 0; word 0 is unchanged (no aliasing).
- Latched request: change addr from 0x2 to 0x7 during WAIT of a read. Required: data returned is mem[0x2].

Source files
------------

// File: rtl/bus_slave_mem.sv
// bus_slave_mem: word-addressed 2^ADDR_W x 32 RAM bus target with WAIT_CYCLES wait states and a one-cycle rdy_ acknowledge
// ports: clk; reset (async, active low); cs_/as_ request strobes (active low); rw (1=read);
//        addr word address; wr_data write data; rd_data read data (0 outside a read ack); rdy_ ack strobe (active low)
module bus_slave_mem #(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cs_,
    input  logic        as_,
    input  logic        rw,
    input  logic [29:0] addr,
    input  logic [31:0] wr_data,
    output logic [31:0] rd_data,
    output logic        rdy_
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_ACK  = 2'd2;
    logic [31:0]       mem [2**ADDR_W];
    logic [1:0]        state;
    logic [3:0]        cnt;
    logic [ADDR_W-1:0] l_idx, a_idx;
    logic              l_oor, a_oor, l_rw, a_rw, req, idle, go_ack;
    logic [31:0]       l_wd, a_wd;
    // with no wait states the access completes on the accepting edge, so the live bus values stand in for the latch
    always_comb begin
        req    = !cs_ && !as_;
        idle   = state == S_IDLE;
        a_idx  = idle ? addr[ADDR_W-1:0] : l_idx;
        a_oor  = idle ? |(addr >> ADDR_W) : l_oor;
        a_rw   = idle ? rw : l_rw;
        a_wd   = idle ? wr_data : l_wd;
        go_ack = req && (idle ? WAIT_CYCLES == 0 : (state == S_WAIT && cnt == 4'd0));
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            cnt     <= '0;
            rdy_    <= 1'b1;
            rd_data <= '0;
            l_idx   <= '0;
            l_oor   <= 1'b0;
            l_rw    <= 1'b0;
            l_wd    <= '0;
        end else begin
            rdy_    <= !go_ack;
            rd_data <= (go_ack && a_rw && !a_oor) ? mem[a_idx] : '0;
            if (go_ack && !a_rw && !a_oor)
                mem[a_idx] <= a_wd;
            case (state)
                S_IDLE: if (req) begin
                    l_idx <= a_idx;
                    l_oor <= a_oor;
                    l_rw  <= rw;
                    l_wd  <= wr_data;
                    state <= (WAIT_CYCLES == 0) ? S_ACK : S_WAIT;
                    cnt   <= (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);
                end
                S_WAIT: begin
                    state <= !req ? S_IDLE : (cnt == 4'd0) ? S_ACK : S_WAIT;
                    cnt   <= (req && cnt != 4'd0) ? cnt - 4'd1 : cnt;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bus_slave_mem.sv
// tb_bus_slave_mem: directed checks of bus_slave_mem with WAIT_CYCLES of 1, 0 and 3
module tb_bus_slave_mem;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  cs_ = '1, as_ = '1, rw = '0, rdy_;
    logic [29:0] addr [3];
    logic [31:0] wr_data [3], rd_data [3];
    int          pass_cnt = 0, total = 0;

    always #5 clk = ~clk;

    bus_slave_mem #(.ADDR_W(10), .WAIT_CYCLES(1)) u0 (.clk(clk), .reset(reset), .cs_(cs_[0]), .as_(as_[0]), .rw(rw[0]),
        .addr(addr[0]), .wr_data(wr_data[0]), .rd_data(rd_data[0]), .rdy_(rdy_[0]));
    bus_slave_mem #(.ADDR_W(10), .WAIT_CYCLES(0)) u1 (.clk(clk), .reset(reset), .cs_(cs_[1]), .as_(as_[1]), .rw(rw[1]),
        .addr(addr[1]), .wr_data(wr_data[1]), .rd_data(rd_data[1]), .rdy_(rdy_[1]));
    bus_slave_mem #(.ADDR_W(10), .WAIT_CYCLES(3)) u2 (.clk(clk), .reset(reset), .cs_(cs_[2]), .as_(as_[2]), .rw(rw[2]),
        .addr(addr[2]), .wr_data(wr_data[2]), .rd_data(rd_data[2]), .rdy_(rdy_[2]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic chk_rdy(input string tag, input int i, input logic exp);
        chk(tag, {31'b0, rdy_[i]}, {31'b0, exp});
    endtask

    task automatic acc(input int i, input int w, input logic r, input logic [29:0] a, input logic [31:0] d,
                       input logic [31:0] exp, input logic [29:0] a_late, input string tag);
        cs_[i] = 1'b0; as_[i] = 1'b0; rw[i] = r; addr[i] = a; wr_data[i] = d;
        for (int k = 0; k <= w; k++) begin
            @(negedge clk);
            chk_rdy({tag, " rdy_"}, i, k != w);
            chk({tag, " rd_data"}, rd_data[i], (k == w && r) ? exp : 32'h0);
            if (k == 0) addr[i] = a_late;
        end
        @(negedge clk);
        chk_rdy({tag, " post rdy_"}, i, 1'b1);
        chk({tag, " post rd_data"}, rd_data[i], 32'h0);
        cs_[i] = 1'b1; as_[i] = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin addr[i] = '0; wr_data[i] = '0; end
        #2 reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk_rdy("reset rdy_", i, 1'b1);
            chk("reset rd_data", rd_data[i], 32'h0);
        end
        @(negedge clk);
        acc(0, 1, 1'b0, 30'h3, 32'h12345678, 32'h0, 30'h3, "w1 write");
        acc(0, 1, 1'b1, 30'h3, 32'h0, 32'h12345678, 30'h3, "w1 read");
        cs_[1] = 1'b0; as_[1] = 1'b0; rw[1] = 1'b0; addr[1] = 30'h0; wr_data[1] = 32'hA5A5A5A5;
        @(negedge clk); chk_rdy("b2b ack0", 1, 1'b0);
        @(negedge clk); chk_rdy("b2b idle", 1, 1'b1);
        addr[1] = 30'h3FF; wr_data[1] = 32'h5A5A5A5A;
        @(negedge clk); chk_rdy("b2b ack1", 1, 1'b0);
        @(negedge clk); chk_rdy("b2b idle1", 1, 1'b1);
        cs_[1] = 1'b1; as_[1] = 1'b1;
        acc(1, 0, 1'b1, 30'h0, 32'h0, 32'hA5A5A5A5, 30'h0, "b2b read0");
        acc(1, 0, 1'b1, 30'h3FF, 32'h0, 32'h5A5A5A5A, 30'h3FF, "b2b read3ff");
        acc(2, 3, 1'b0, 30'h9, 32'h11111111, 32'h0, 30'h9, "abort setup");
        for (int r = 1; r >= 0; r--) begin
            cs_[2] = 1'b0; as_[2] = 1'b0; rw[2] = r[0]; addr[2] = 30'h9; wr_data[2] = 32'h22222222;
            @(negedge clk);
            chk_rdy("abort wait rdy_", 2, 1'b1);
            as_[2] = 1'b1;
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                chk_rdy("abort rdy_", 2, 1'b1);
                chk("abort rd_data", rd_data[2], 32'h0);
            end
            cs_[2] = 1'b1;
        end
        acc(2, 3, 1'b1, 30'h9, 32'h0, 32'h11111111, 30'h9, "abort readback");
        acc(0, 1, 1'b0, 30'h0, 32'h0BADF00D, 32'h0, 30'h0, "oor seed0");
        acc(0, 1, 1'b0, 30'h400, 32'hFFFFFFFF, 32'h0, 30'h400, "oor write");
        acc(0, 1, 1'b1, 30'h400, 32'h0, 32'h0, 30'h400, "oor read");
        acc(0, 1, 1'b1, 30'h0, 32'h0, 32'h0BADF00D, 30'h0, "oor alias");
        acc(2, 3, 1'b0, 30'h2, 32'hAAAA0002, 32'h0, 30'h2, "latch w2");
        acc(2, 3, 1'b0, 30'h7, 32'hBBBB0007, 32'h0, 30'h7, "latch w7");
        acc(2, 3, 1'b1, 30'h2, 32'h0, 32'hAAAA0002, 30'h7, "latch read");
        acc(2, 3, 1'b0, 30'h5, 32'h55555555, 32'h0, 30'h5, "rst seed5");
        cs_[2] = 1'b0; as_[2] = 1'b0; rw[2] = 1'b0; addr[2] = 30'h5; wr_data[2] = 32'hDEADBEEF;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk_rdy("rst wait rdy_", 2, 1'b1);
        chk("rst wait rd_data", rd_data[2], 32'h0);
        @(negedge clk);
        cs_[2] = 1'b1; as_[2] = 1'b1; reset = 1'b1;
        @(negedge clk);
        acc(2, 3, 1'b1, 30'h5, 32'h0, 32'h55555555, 30'h5, "rst readback");
        cs_[0] = 1'b0; as_[0] = 1'b0; rw[0] = 1'b1; addr[0] = 30'h3;
        @(negedge clk);
        @(negedge clk);
        chk_rdy("rst ack rdy_", 0, 1'b0);
        chk("rst ack rd_data", rd_data[0], 32'h12345678);
        reset = 1'b0;
        #1;
        chk_rdy("rst async rdy_", 0, 1'b1);
        chk("rst async rd_data", rd_data[0], 32'h0);
        cs_[0] = 1'b1; as_[0] = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        acc(0, 1, 1'b1, 30'h3, 32'h0, 32'h12345678, 30'h3, "post rst read");
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
